// File: rtl/dcache_pkg.sv
// dcache_pkg: shared data-cache geometry and flush-walker state encoding
package dcache_pkg;
    localparam int DEF_PABITS = 36;
    localparam int NSETS      = 64;
    localparam int IDXW       = 6;
    localparam int OFFW       = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WB,
        S_UPDATE,
        S_DONE
    } state_t;
endpackage

// File: rtl/dcache_flush_walker.sv
// dcache_flush_walker: walks all sets, writes back dirty lines and optionally invalidates
module dcache_flush_walker
    import dcache_pkg::*;
#(
    parameter int PABITS = DEF_PABITS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          Flush_Req,
    input  logic                          Flush_Invalidate,
    output logic                          Flush_Busy,
    output logic                          Flush_Done,
    output logic [6:0]                    Flush_Count,
    output logic [IDXW-1:0]               Tag_Index,
    output logic                          Tag_Write,
    output logic                          Tag_Valid,
    output logic                          Tag_Dirty,
    output logic [PABITS-IDXW-OFFW-1:0]   Tag_Set,
    input  logic [PABITS-IDXW-OFFW-1:0]   Tag_MatchTag,
    input  logic                          Tag_MatchValid,
    input  logic                          Tag_MatchDirty,
    output logic                          WB_Req,
    output logic [PABITS-OFFW-1:0]        WB_Addr,
    input  logic                          WB_Ready
);
    localparam int TW = PABITS - IDXW - OFFW;
    state_t          state, next;
    logic [IDXW-1:0] idx;
    logic [TW-1:0]   tag_q;
    logic            inv_q;
    logic            adv;
    logic            last;
    assign last = idx == IDXW'(NSETS - 1);
    // State register plus walk index, latched tag/invalidate flag and writeback count
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            tag_q       <= '0;
            inv_q       <= 1'b0;
            Flush_Count <= '0;
        end else begin
            state <= next;
            if (state == S_IDLE) idx <= '0;
            else if (adv) idx <= idx + 1'b1;
            if (state == S_IDLE && Flush_Req) begin
                inv_q       <= Flush_Invalidate;
                Flush_Count <= '0;
            end
            if (state == S_CHECK) tag_q <= Tag_MatchTag;
            if (state == S_WB && WB_Ready) Flush_Count <= Flush_Count + 7'd1;
        end
    end
    // Next-state and Moore outputs; RAM read data is consumed in CHECK, one cycle after READ
    always_comb begin
        next       = state;
        adv        = 1'b0;
        Tag_Index  = idx;
        Tag_Write  = 1'b0;
        Tag_Valid  = 1'b0;
        Tag_Dirty  = 1'b0;
        Tag_Set    = '0;
        WB_Req     = 1'b0;
        WB_Addr    = '0;
        Flush_Busy = state != S_IDLE;
        Flush_Done = state == S_DONE;
        case (state)
            S_IDLE:  next = Flush_Req ? S_READ : S_IDLE;
            S_READ:  next = S_CHECK;
            S_CHECK: begin
                if (Tag_MatchValid && Tag_MatchDirty) next = S_WB;
                else if (Tag_MatchValid && inv_q) next = S_UPDATE;
                else if (last) next = S_DONE;
                else begin
                    next = S_READ;
                    adv  = 1'b1;
                end
            end
            S_WB: begin
                WB_Req  = 1'b1;
                WB_Addr = {tag_q, idx};
                next    = WB_Ready ? S_UPDATE : S_WB;
            end
            S_UPDATE: begin
                Tag_Write = 1'b1;
                Tag_Set   = tag_q;
                Tag_Valid = ~inv_q;
                next      = last ? S_DONE : S_READ;
                adv       = ~last;
            end
            S_DONE:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end
endmodule

// File: doc/dcache_flush_walker.md
DCACHE_FLUSH_WALKER -- requirements
Module: dcache_flush_walker

Interface
REQ-001 Parameter: PABITS, default 36, physical address width; tag width TW = PABITS-10 bits; 64 sets; 16-byte lines.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Flush_Req  in  1  start flush when high in IDLE; ignored otherwise.
REQ-005 Flush_Invalidate  in  1  sampled with Flush_Req; 1 = also clear Valid of every valid line visited.
REQ-006 Flush_Busy  out  1  high from the cycle after Flush_Req is accepted until DONE is exited.
REQ-007 Flush_Done  out  1  one-cycle pulse at completion.
REQ-008 Flush_Count  out  7  number of writebacks issued by the current or last flush.
REQ-009 Tag_Index  out  6  set index to the tag/flag RAM.
REQ-010 Tag_Write  out  1  tag/flag RAM write enable.
REQ-011 Tag_Valid, Tag_Dirty  out  1 each  flag values written when Tag_Write=1.
REQ-012 Tag_Set  out  TW  tag value written when Tag_Write=1.
REQ-013 Tag_MatchTag  in  TW; Tag_MatchValid, Tag_MatchDirty  in  1 each  RAM read data, one-cycle latency after Tag_Index.
REQ-014 WB_Req  out  1  writeback request valid.
REQ-015 WB_Addr  out  PABITS-4  line address {tag, index}.
REQ-016 WB_Ready  in  1  downstream accepts; transfer occurs in any cycle with WB_Req=1 and WB_Ready=1.

Function
REQ-017 States: IDLE, READ, CHECK, WB, UPDATE, DONE; index register idx (6 bits), latched tag, latched invalidate flag.
REQ-018 IDLE: idx=0; Flush_Req=1 -> latch Flush_Invalidate, clear Flush_Count, go to READ.
REQ-019 READ: Tag_Index=idx, Tag_Write=0; go to CHECK.
REQ-020 CHECK: latch Tag_MatchTag; if Valid&Dirty -> WB; else if Valid&invalidate -> UPDATE; else if idx=63 -> DONE; else idx+1 -> READ.
REQ-021 WB: WB_Req=1, WB_Addr={latched tag, idx}; both held stable until accepted; on accept increment Flush_Count, go to UPDATE.
REQ-022 UPDATE: Tag_Index=idx, Tag_Write=1, Tag_Set=latched tag, Tag_Dirty=0, Tag_Valid=~invalidate; then idx=63 -> DONE, else idx+1 -> READ.
REQ-023 DONE: Flush_Done=1 for exactly one cycle; go to IDLE; Flush_Req in DONE is ignored.
REQ-024 Latency: clean line 2 cycles; dirty line with WB_Ready=1 4 cycles; all-clean flush: Flush_Busy high 129 cycles (128 walk + DONE).
REQ-025 Valid=0 lines never written back or written, regardless of Dirty.
REQ-026 Tag_Write=0 and WB_Req=0 in every state other than UPDATE and WB respectively.
REQ-027 idx never wraps: index 63 terminates the walk; Flush_Count saturates naturally at 64.

Reset
REQ-028 reset: state=IDLE, idx=0, Flush_Count=0, Flush_Busy=0, Flush_Done=0, WB_Req=0, Tag_Write=0, Tag_Index=0, Tag_Set=0, Tag_Valid=0, Tag_Dirty=0, WB_Addr=0.
REQ-029 reset mid-flush aborts immediately, including a pending WB; no partial RAM write is issued; next Flush_Req restarts at index 0.

Structure
REQ-030 Shared package dcache_pkg holds PABITS default, set count 64, index width 6, line-offset width 4, and the FSM state encoding.
REQ-031 Single flat module; no sub-module; connects directly to the existing 64-set tag/flag RAM port.

Verification
REQ-032 All 64 lines valid clean, Flush_Req pulse -> Busy 129 cycles, Done pulse once, WB_Req never high, Flush_Count=0.
REQ-033 Index 5 valid dirty tag 0x0ABCDEF, WB_Ready=1 -> WB_Addr=0x2AF37BC5, then Tag_Write at index 5 with Valid=1, Dirty=0, Tag_Set=0x0ABCDEF; Flush_Count=1.
REQ-034 Same as REQ-033 with WB_Ready low 10 cycles -> WB_Req and WB_Addr stable all 10 cycles, no Tag_Write until accept.
REQ-035 Flush_Invalidate=1, all lines valid clean -> 64 writes with Valid=0, Dirty=0, no writebacks.
REQ-036 Index 9 Dirty=1, Valid=0 -> no WB_Req, no Tag_Write at index 9.
REQ-037 reset asserted in WB at idx=20 -> next cycle Busy=0, WB_Req=0, Flush_Count=0; new Flush_Req reads index 0 first.
